// File: rtl/pixel_stream_pkg.sv
// Shared types and helpers for the pixel stream path.
//   pixel_beat_t : one buffered beat (pixel address, colour word, frame-last tag,
//                  frame-buffer select captured when the beat was queued)
//   colour_of()  : iteration count -> colour word, also used by the VGA readback
package pixel_stream_pkg;

  localparam int NUM_COLUMNS   = 640;
  localparam int NUM_ROWS      = 480;
  localparam int STREAM_ADDR_W = 19;
  localparam int MEM_ADDR_W    = 20;
  localparam int COLOR_W       = 8;

  typedef struct packed {
    logic [STREAM_ADDR_W-1:0] addr;
    logic [COLOR_W-1:0]       colour;
    logic                     last;
    logic                     buf_sel;
  } pixel_beat_t;

  typedef enum logic {
    ST_IDLE,
    ST_IN_FRAME
  } frame_state_e;

  // Points in the set are black; everything else uses the low bits of the
  // count, nudged off zero so escaping points never alias to black.
  function automatic logic [COLOR_W-1:0] colour_of(input logic [31:0] iter,
                                                   input logic [31:0] max_iter);
    logic [COLOR_W-1:0] c;
    c = iter[COLOR_W-1:0];
    if (iter >= max_iter) return '0;
    if (c == '0) return COLOR_W'(1);
    return c;
  endfunction

endpackage

// File: rtl/pixel_stream_writer_if.sv
// Stream + memory-port bundle for pixel_stream_writer.
//   slave  : the writer's view (consumes the stream, drives the memory port)
//   master : the environment's view (solver side + frame-buffer controller)
interface pixel_stream_writer_if #(
  parameter int ITER_W = 16
);
  import pixel_stream_pkg::*;

  logic                     valid_stream;
  logic                     start_stream;
  logic                     end_stream;
  logic [STREAM_ADDR_W-1:0] solver_addr;
  logic [ITER_W-1:0]        pixel_iter;
  logic                     stream_ready;

  logic                     mem_write;
  logic [MEM_ADDR_W-1:0]    mem_addr;
  logic [COLOR_W-1:0]       mem_writedata;
  logic                     mem_waitrequest;

  modport slave (
    input  valid_stream, start_stream, end_stream, solver_addr, pixel_iter,
    output stream_ready,
    output mem_write, mem_addr, mem_writedata,
    input  mem_waitrequest
  );

  modport master (
    output valid_stream, start_stream, end_stream, solver_addr, pixel_iter,
    input  stream_ready,
    input  mem_write, mem_addr, mem_writedata,
    output mem_waitrequest
  );

endinterface

// File: rtl/pixel_stream_writer_fifo.sv
// Synchronous FIFO, power-of-two DEPTH, registered occupancy count.
//   wr_en/wr_data : enqueue (ignored when full unless a pop happens same cycle)
//   rd_en/rd_data : rd_data is the head (show-ahead); rd_en pops it
//   empty/full/count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_wr, do_rd;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  // At full, a same-cycle pop frees the slot being overwritten.
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/pixel_stream_writer.sv
// Consumer end of the solver pixel stream: frames beats, maps counts to colour,
// queues them and writes a double-buffered frame buffer over a waitrequest port.
//   clock, reset_n      : single domain, async active-low reset
//   bus (slave)         : stream in + memory write port out
//   display_buf         : buffer holding the last completed frame
//   frame_done          : 1-cycle pulse after the final beat of a frame is written
//   frame_error         : sticky framing violation
//   overflow_error      : sticky, a beat arrived with the FIFO full
module pixel_stream_writer
  import pixel_stream_pkg::*;
#(
  parameter int ITER_W     = 16,
  parameter int MAX_ITER   = 1000,
  parameter int FIFO_DEPTH = 8,
  parameter int BUF_STRIDE = 2**19
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pixel_stream_writer_if.slave  bus,
  output logic                  display_buf,
  output logic                  frame_done,
  output logic                  frame_error,
  output logic                  overflow_error
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  frame_state_e     state, state_nxt;
  logic             beat_ok, beat_last, set_ferr;
  logic             push, pop, full, empty;
  logic             enq_buf, write_buf;
  logic [CNT_W-1:0] count;
  pixel_beat_t      wr_beat, head;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    beat_ok   = 1'b0;
    beat_last = 1'b0;
    set_ferr  = 1'b0;
    if (bus.valid_stream) begin
      case (state)
        ST_IDLE: begin
          if (bus.start_stream) begin
            beat_ok = 1'b1;
            if (bus.end_stream) beat_last = 1'b1;
            else                state_nxt = ST_IN_FRAME;
          end else begin
            set_ferr = 1'b1;
          end
        end
        ST_IN_FRAME: begin
          beat_ok = 1'b1;
          // A fresh start mid-frame restarts the frame on this beat.
          if (bus.start_stream) set_ferr = 1'b1;
          if (bus.end_stream) begin
            beat_last = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign pop  = bus.mem_write & ~bus.mem_waitrequest;
  assign push = beat_ok & (~full | pop);
  assign bus.stream_ready = (count <= CNT_W'(FIFO_DEPTH - 3));

  // enq_buf is the enqueue-side view of write_buf: it flips when a frame's last
  // beat is queued, so beats of the next frame already carry the buffer that
  // write_buf will hold by the time they reach the memory port.
  always_comb begin
    wr_beat.addr    = bus.solver_addr;
    wr_beat.colour  = colour_of(32'(bus.pixel_iter), 32'(MAX_ITER));
    wr_beat.last    = beat_last;
    wr_beat.buf_sel = enq_buf;
  end

  sync_fifo #(
    .WIDTH($bits(pixel_beat_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (push),
    .wr_data (wr_beat),
    .rd_en   (pop),
    .rd_data (head),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  // Memory request register: the head stays in the FIFO until accepted, so
  // after each accept the register idles one cycle to pick up the new head.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_write     <= 1'b0;
      bus.mem_addr      <= '0;
      bus.mem_writedata <= '0;
    end else if (!bus.mem_write) begin
      if (!empty) begin
        bus.mem_write     <= 1'b1;
        bus.mem_addr      <= MEM_ADDR_W'(head.addr) +
                             (head.buf_sel ? MEM_ADDR_W'(BUF_STRIDE) : MEM_ADDR_W'(0));
        bus.mem_writedata <= head.colour;
      end
    end else if (!bus.mem_waitrequest) begin
      bus.mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      enq_buf        <= 1'b0;
      write_buf      <= 1'b0;
      display_buf    <= 1'b1;
      frame_done     <= 1'b0;
      frame_error    <= 1'b0;
      overflow_error <= 1'b0;
    end else begin
      if (push & beat_last) enq_buf <= ~enq_buf;
      frame_done <= pop & head.last;
      if (pop & head.last) begin
        display_buf <= write_buf;
        write_buf   <= ~write_buf;
      end
      if (set_ferr)                 frame_error    <= 1'b1;
      if (beat_ok & full & ~pop)    overflow_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pixel_stream_writer.sv
module tb_pixel_stream_writer;
  import pixel_stream_pkg::*;

  localparam int STRIDE = 1 << 19;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic display_buf, frame_done, frame_error, overflow_error;

  pixel_stream_writer_if #(.ITER_W(16)) bus ();

  pixel_stream_writer #(
    .ITER_W(16), .MAX_ITER(1000), .FIFO_DEPTH(8), .BUF_STRIDE(STRIDE)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .bus            (bus),
    .display_buf    (display_buf),
    .frame_done     (frame_done),
    .frame_error    (frame_error),
    .overflow_error (overflow_error)
  );

  always #5 clock = ~clock;

  typedef struct {
    int addr;
    int data;
    bit last;
    bit bsel;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   cyc = 0;
  int   pend_cyc = 0;
  bit   pend_done = 0;
  bit   pend_disp = 0;
  bit   enq_buf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int colour(input int iter);
    int c;
    if (iter >= 1000) return 0;
    c = iter % 256;
    return (c == 0) ? 1 : c;
  endfunction

  // Scoreboard monitor: samples on the falling edge.
  task automatic monitor();
    bit   hv;
    int   ha, hd;
    exp_t e;
    hv = 0; ha = 0; hd = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        hv = 0;
        pend_done = 0;
      end else begin
        if (hv) begin
          chk("hold_write", 32'(bus.mem_write), 1);
          chk("hold_addr", 32'(bus.mem_addr), ha);
          chk("hold_data", 32'(bus.mem_writedata), hd);
        end
        hv = bus.mem_write && bus.mem_waitrequest;
        ha = 32'(bus.mem_addr);
        hd = 32'(bus.mem_writedata);
        if (frame_done) begin
          done_seen++;
          chk("done_expected", 32'(pend_done), 1);
          chk("done_timing", cyc, pend_cyc);
          chk("done_display_buf", 32'(display_buf), 32'(pend_disp));
          pend_done = 0;
        end
        if (bus.mem_write && !bus.mem_waitrequest) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: addr %0h data %0h, no write expected",
                     bus.mem_addr, bus.mem_writedata);
          end else begin
            e = q.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), e.addr);
            chk("wr_data", 32'(bus.mem_writedata), e.data);
            if (e.last) begin
              pend_done = 1;
              pend_cyc  = cyc + 1;
              pend_disp = e.bsel;
            end
          end
        end
      end
    end
  endtask

  task automatic beat(input bit st, input bit en, input int a, input int iter, input bit exp_enq);
    exp_t e;
    @(posedge clock); #1;
    bus.valid_stream = 1'b1;
    bus.start_stream = st;
    bus.end_stream   = en;
    bus.solver_addr  = 19'(a);
    bus.pixel_iter   = 16'(iter);
    if (exp_enq) begin
      e.addr = a + (enq_buf ? STRIDE : 0);
      e.data = colour(iter);
      e.last = en;
      e.bsel = enq_buf;
      q.push_back(e);
      if (en) enq_buf = ~enq_buf;
    end
  endtask

  task automatic idle();
    @(posedge clock); #1;
    bus.valid_stream = 1'b0;
    bus.start_stream = 1'b0;
    bus.end_stream   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || pend_done) && n < 400) begin
      @(posedge clock);
      n++;
    end
    chk({name, "_drain_in_time"}, 32'(n < 400), 1);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_write"}, 32'(bus.mem_write), 0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_mem_writedata"}, 32'(bus.mem_writedata), 0);
    chk({tag, "_display_buf"}, 32'(display_buf), 1);
    chk({tag, "_frame_done"}, 32'(frame_done), 0);
    chk({tag, "_frame_error"}, 32'(frame_error), 0);
    chk({tag, "_overflow_error"}, 32'(overflow_error), 0);
    chk({tag, "_stream_ready"}, 32'(bus.stream_ready), 1);
  endtask

  initial begin
    bus.valid_stream = 1'b0;
    bus.start_stream = 1'b0;
    bus.end_stream = 1'b0;
    bus.solver_addr = '0;
    bus.pixel_iter = '0;
    bus.mem_waitrequest = 1'b0;
    fork
      monitor();
    join_none

    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    @(negedge clock); #2;
    reset_n = 1'b1;

    // T1: 4x2 frame back-to-back, iter = addr+1
    for (int i = 0; i < 8; i++) beat(i == 0, i == 7, i, i + 1, 1);
    // T2: next frame follows immediately into buffer 1 while T1 drains
    for (int i = 0; i < 8; i++) begin
      beat(i == 0, i == 7, i, i + 1, 1);
      idle();
    end
    drain("t2");
    chk("t2_done_count", done_seen, 2);
    chk("t2_display_buf", 32'(display_buf), 1);

    // T3: memory stalls while the FIFO fills
    bus.mem_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) beat(i == 0, 0, i, i + 1, 1);
    idle();
    @(negedge clock);
    chk("t3_ready_at_5", 32'(bus.stream_ready), 1);
    chk("t3_write_held", 32'(bus.mem_write), 1);
    beat(0, 0, 5, 6, 1);
    idle();
    @(negedge clock);
    chk("t3_ready_at_6", 32'(bus.stream_ready), 0);
    chk("t3_no_overflow", 32'(overflow_error), 0);
    @(posedge clock); #1;
    bus.mem_waitrequest = 1'b0;
    beat(0, 0, 6, 7, 1);
    beat(0, 1, 7, 8, 1);
    idle();
    drain("t3");
    chk("t3_done_count", done_seen, 3);
    chk("t3_overflow", 32'(overflow_error), 0);

    // T4: 12 beats into a stalled port, only 8 fit
    bus.mem_waitrequest = 1'b1;
    for (int i = 0; i < 12; i++) beat(i == 0, 0, i, i + 1, i < 8);
    idle();
    @(negedge clock);
    chk("t4_overflow", 32'(overflow_error), 1);
    chk("t4_frame_error", 32'(frame_error), 0);
    chk("t4_ready", 32'(bus.stream_ready), 0);
    @(posedge clock); #1;
    bus.mem_waitrequest = 1'b0;
    drain("t4a");
    beat(0, 1, 12, 13, 1);
    idle();
    drain("t4b");
    chk("t4_done_count", done_seen, 4);

    // T5: restart mid-frame, then a stray beat in IDLE
    beat(1, 0, 0, 20, 1);
    beat(0, 0, 1, 21, 1);
    beat(1, 0, 2, 22, 1);
    beat(0, 0, 3, 23, 1);
    beat(0, 1, 4, 24, 1);
    idle();
    drain("t5a");
    chk("t5_frame_error", 32'(frame_error), 1);
    chk("t5_done_count", done_seen, 5);
    beat(0, 0, 9, 9, 0);
    idle();
    repeat (8) @(posedge clock);
    #1;
    chk("t5_stray_no_done", done_seen, 5);
    chk("t5_stray_no_write", 32'(bus.mem_write), 0);

    // T6: colour boundaries
    beat(1, 0, 10, 1000, 1);
    beat(0, 0, 11, 256, 1);
    beat(0, 0, 12, 999, 1);
    beat(0, 1, 13, 5000, 1);
    idle();
    drain("t6a");
    chk("t6_done_count", done_seen, 6);
    chk("t6_display_buf", 32'(display_buf), 1);

    // Reset mid-frame with beats queued and a request pending
    bus.mem_waitrequest = 1'b1;
    beat(1, 0, 20, 7, 0);
    beat(0, 0, 21, 8, 0);
    idle();
    repeat (2) @(posedge clock);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    q.delete();
    enq_buf = 0;
    repeat (2) @(negedge clock);
    #2;
    reset_n = 1'b1;
    bus.mem_waitrequest = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    chk("midreset_no_done", done_seen, 6);
    chk("midreset_idle_port", 32'(bus.mem_write), 0);

    // Single-beat frame after reset lands in buffer 0
    beat(1, 1, 3, 5, 1);
    idle();
    drain("single");
    chk("single_done_count", done_seen, 7);
    chk("single_display_buf", 32'(display_buf), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
